// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared state encodings, bus direction codes and widths for the memory bus
package gb_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arbState_t;

    // index width for selecting one of n items, never narrower than one bit
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester handshake and shared memory bus bundle
interface mem_bus_arbiter_if
    import gb_bus_pkg::*;
#(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [ADDR_W*NUM_REQ-1:0] addr;
    logic [DATA_W*NUM_REQ-1:0] wdata;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         memAddress;
    logic [DATA_W-1:0]         memDataW;
    logic                      RW;
    logic [DATA_W-1:0]         memDataR;

    // requesters plus the memory decode that answers reads
    modport master (
        output req, lock, addr, wdata, we, memDataR,
        input  gnt, ack, rdata, memAddress, memDataW, RW
    );

    // the arbiter itself
    modport slave (
        input  req, lock, addr, wdata, we, memDataR,
        output gnt, ack, rdata, memAddress, memDataW, RW
    );

endinterface

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational requester select scanning up or down from a start index
module arb_pick
    import gb_bus_pkg::*;
#(
    parameter int N       = 3,
    parameter bit SCAN_UP = 1'b0,
    parameter int IW      = idxWidth(N)
) (
    input  logic [N-1:0]  reqVec,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] pickIdx,
    output logic          pickValid
);

    // walk the search order from its far end so the earliest set candidate is the one left standing
    always_comb begin
        logic [IW-1:0] cand;
        pickIdx   = '0;
        pickValid = 1'b0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (SCAN_UP) begin
                cand = IW'((int'(start) + k) % N);
            end else begin
                cand = IW'((int'(start) + N - k) % N);
            end
            if (reqVec[cand]) begin
                pickIdx   = cand;
                pickValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - one-access-at-a-time bus arbiter with burst lock; BUS_ARB_ROUND_ROBIN_EN selects rotating priority
module mem_bus_arbiter
    import gb_bus_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_LOCK      = 160
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);

    localparam int IW    = idxWidth(NUM_REQ);
    localparam int CNT_W = idxWidth(ACCESS_CYCLES + 1);
    localparam int LCK_W = idxWidth(MAX_LOCK);

    arbState_t          state, stateNext;
    logic [IW-1:0]      owner, ownerNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [LCK_W-1:0]   lockCnt, lockCntNext;
    logic [NUM_REQ-1:0] gntQ, gntNext;
    logic [NUM_REQ-1:0] ackQ, ackNext;
    logic [DATA_W-1:0]  rdataQ, rdataNext;
    logic [ADDR_W-1:0]  memAddressQ, memAddressNext;
    logic [DATA_W-1:0]  memDataWQ, memDataWNext;
    logic               rwQ, rwNext;

    logic [IW-1:0]      searchStart;
    logic [IW-1:0]      pickIdx;
    logic               pickValid;
    logic [IW-1:0]      loadIdx;
    logic               accessDone;
    logic               regrant;
    logic               grantLoad;

    logic [ADDR_W-1:0]  addrArr  [NUM_REQ];
    logic [DATA_W-1:0]  wdataArr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gSlice
        assign addrArr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
        assign wdataArr[g] = bus.wdata[g*DATA_W +: DATA_W];
    end

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam bit SCAN_UP = 1'b1;
    logic [IW-1:0] lastOwner;

    // remember the latest grantee so the next search begins just past it
    always_ff @(posedge clk) begin
        if (reset) begin
            lastOwner <= IW'(NUM_REQ - 1);
        end else if (state == ARB_IDLE && pickValid) begin
            lastOwner <= pickIdx;
        end
    end

    assign searchStart = (lastOwner == IW'(NUM_REQ - 1)) ? '0 : lastOwner + 1'b1;
`else
    localparam bit SCAN_UP = 1'b0;
    assign searchStart = IW'(NUM_REQ - 1);
`endif

    arb_pick #(
        .N       (NUM_REQ),
        .SCAN_UP (SCAN_UP),
        .IW      (IW)
    ) pickInst (
        .reqVec    (bus.req),
        .start     (searchStart),
        .pickIdx   (pickIdx),
        .pickValid (pickValid)
    );

    assign accessDone = (state == ARB_ACCESS) && (cnt == CNT_W'(ACCESS_CYCLES));
    assign regrant    = (state == ARB_DONE) && bus.lock[owner] && bus.req[owner]
                        && (int'(lockCnt) < MAX_LOCK - 1);
    assign grantLoad  = ((state == ARB_IDLE) && pickValid) || regrant;
    assign loadIdx    = (state == ARB_DONE) ? owner : pickIdx;

    // state and every bus-facing output are registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            owner       <= '0;
            cnt         <= '0;
            lockCnt     <= '0;
            gntQ        <= '0;
            ackQ        <= '0;
            rdataQ      <= '0;
            memAddressQ <= '0;
            memDataWQ   <= '0;
            rwQ         <= RW_READ;
        end else begin
            state       <= stateNext;
            owner       <= ownerNext;
            cnt         <= cntNext;
            lockCnt     <= lockCntNext;
            gntQ        <= gntNext;
            ackQ        <= ackNext;
            rdataQ      <= rdataNext;
            memAddressQ <= memAddressNext;
            memDataWQ   <= memDataWNext;
            rwQ         <= rwNext;
        end
    end

    // sequencing: grant, hold the bus for the access, then either re-grant a locked owner or re-arbitrate
    always_comb begin
        stateNext = state;
        case (state)
            ARB_IDLE:   if (pickValid) stateNext = ARB_ACCESS;
            ARB_ACCESS: if (accessDone) stateNext = ARB_DONE;
            ARB_DONE:   stateNext = regrant ? ARB_ACCESS : ARB_IDLE;
            default:    stateNext = ARB_IDLE;
        endcase
    end

    // next values of the bus, handshake and counter registers
    always_comb begin
        ownerNext      = owner;
        cntNext        = cnt;
        lockCntNext    = lockCnt;
        gntNext        = gntQ;
        ackNext        = '0;
        rdataNext      = rdataQ;
        memAddressNext = memAddressQ;
        memDataWNext   = memDataWQ;
        rwNext         = rwQ;

        case (state)
            ARB_IDLE: begin
                if (!pickValid) begin
                    rwNext  = RW_READ;
                    gntNext = '0;
                end
            end
            ARB_ACCESS: begin
                if (accessDone) begin
                    if (rwQ == RW_READ) begin
                        rdataNext = bus.memDataR;
                    end
                    ackNext = NUM_REQ'(1) << owner;
                    rwNext  = RW_READ;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            ARB_DONE: begin
                if (regrant) begin
                    lockCntNext = lockCnt + 1'b1;
                end else begin
                    gntNext     = '0;
                    lockCntNext = '0;
                end
            end
            default: begin
                gntNext = '0;
                rwNext  = RW_READ;
            end
        endcase

        if (grantLoad) begin
            ownerNext      = loadIdx;
            memAddressNext = addrArr[loadIdx];
            memDataWNext   = wdataArr[loadIdx];
            rwNext         = bus.we[loadIdx] ? RW_WRITE : RW_READ;
            gntNext        = NUM_REQ'(1) << loadIdx;
            cntNext        = CNT_W'(1);
        end
    end

    assign bus.gnt        = gntQ;
    assign bus.ack        = ackQ;
    assign bus.rdata      = rdataQ;
    assign bus.memAddress = memAddressQ;
    assign bus.memDataW   = memDataWQ;
    assign bus.RW         = rwQ;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    import gb_bus_pkg::*;

    localparam int NUM_REQ       = 3;
    localparam int ACCESS_CYCLES = 2;
    localparam int MAX_LOCK      = 160;

    typedef struct {
        int                idx;
        logic              isWrite;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } access_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    int                testCount = 0;
    int                failCount = 0;
    access_t           scoreboard[$];
    logic [DATA_W-1:0] modelRdata = '0;

    mem_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    mem_bus_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .ACCESS_CYCLES (ACCESS_CYCLES),
        .MAX_LOCK      (MAX_LOCK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] memModel(input logic [ADDR_W-1:0] a);
        return a[7:0] + 8'h5A;
    endfunction

    assign bus.memDataR = memModel(bus.memAddress);

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input int i, input logic r, input logic l, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req[i]                    = r;
        bus.lock[i]                   = l;
        bus.we[i]                     = w;
        bus.addr[ADDR_W*i +: ADDR_W]  = a;
        bus.wdata[DATA_W*i +: DATA_W] = d;
    endtask

    task automatic expectAccess(input int i, input logic w, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d);
        access_t e;
        e.idx     = i;
        e.isWrite = w;
        e.addr    = a;
        e.data    = d;
        scoreboard.push_back(e);
    endtask

    task automatic waitAck(input int idx, input int budget, input string tag, output int waited);
        logic [NUM_REQ-1:0] sel;
        sel    = NUM_REQ'(1) << idx;
        waited = 0;
        while (waited < budget) begin
            @(negedge clk);
            waited++;
            if ((bus.ack & sel) != '0) return;
        end
        testCount++;
        failCount++;
        $display("FAIL %s: no ack from requester %0d within %0d cycles", tag, idx, budget);
    endtask

    // scoreboard side: bus invariants every cycle, completed accesses checked in order
    always @(negedge clk) begin
        access_t want;
        if (!reset) begin
            check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            check("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
            check("ack_implies_gnt", 32'(bus.ack & ~bus.gnt), 32'd0);
            if (bus.ack != '0) begin
                if (scoreboard.size() == 0) begin
                    check("unexpected_ack", 32'(bus.ack), 32'd0);
                end else begin
                    want = scoreboard.pop_front();
                    check("ack_owner", 32'(bus.ack), 32'd1 << want.idx);
                    check("ack_addr", 32'(bus.memAddress), 32'(want.addr));
                    check("ack_rw_low", 32'(bus.RW), 32'd0);
                    if (want.isWrite) begin
                        check("ack_wdata", 32'(bus.memDataW), 32'(want.data));
                    end else begin
                        modelRdata = memModel(want.addr);
                    end
                    check("ack_rdata", 32'(bus.rdata), 32'(modelRdata));
                end
            end
        end
    end

    initial begin
        int n;
        int runLen;
        bus.req   = '0;
        bus.lock  = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_addr", 32'(bus.memAddress), 32'd0);
        check("rst_wdata", 32'(bus.memDataW), 32'd0);
        check("rst_rw", 32'(bus.RW), 32'd0);
        reset = 1'b0;

        // single read
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 16'hC000, 8'h00);
        expectAccess(0, 1'b0, 16'hC000, 8'h00);
        for (int c = 1; c <= ACCESS_CYCLES; c++) begin
            @(negedge clk);
            check("rd_addr", 32'(bus.memAddress), 32'hC000);
            check("rd_rw", 32'(bus.RW), 32'd0);
            check("rd_gnt", 32'(bus.gnt), 32'h1);
            check("rd_no_ack", 32'(bus.ack), 32'd0);
        end
        @(negedge clk);
        check("rd_ack", 32'(bus.ack), 32'h1);
        check("rd_rdata", 32'(bus.rdata), 32'h5A);
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        check("rd_idle_gnt", 32'(bus.gnt), 32'd0);

        // single write
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b1, 16'hFF80, 8'h3C);
        expectAccess(1, 1'b1, 16'hFF80, 8'h3C);
        for (int c = 1; c <= ACCESS_CYCLES; c++) begin
            @(negedge clk);
            check("wr_addr", 32'(bus.memAddress), 32'hFF80);
            check("wr_rw", 32'(bus.RW), 32'd1);
            check("wr_data", 32'(bus.memDataW), 32'h3C);
            check("wr_gnt", 32'(bus.gnt), 32'h2);
        end
        @(negedge clk);
        check("wr_ack", 32'(bus.ack), 32'h2);
        check("wr_rw_done", 32'(bus.RW), 32'd0);
        check("wr_rdata_kept", 32'(bus.rdata), 32'h5A);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);

`ifndef BUS_ARB_ROUND_ROBIN_EN
        // contention: highest index first, one ARB cycle, then the loser
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 16'h1234, 8'h00);
        drive(2, 1'b1, 1'b0, 1'b0, 16'h2345, 8'h00);
        expectAccess(2, 1'b0, 16'h2345, 8'h00);
        expectAccess(0, 1'b0, 16'h1234, 8'h00);
        waitAck(2, 12, "cont_ack2", n);
        check("cont_lat2", 32'(n), 32'(ACCESS_CYCLES + 1));
        check("cont_gnt2", 32'(bus.gnt), 32'h4);
        drive(2, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        check("cont_arb_gnt", 32'(bus.gnt), 32'd0);
        @(negedge clk);
        check("cont_gnt0", 32'(bus.gnt), 32'h1);
        waitAck(0, 12, "cont_ack0", n);
        check("cont_lat0", 32'(n), 32'(ACCESS_CYCLES));
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);

        // locked burst of four with requester 0 waiting
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0042, 8'h00);
        drive(2, 1'b1, 1'b1, 1'b0, 16'hFE00, 8'h00);
        expectAccess(2, 1'b0, 16'hFE00, 8'h00);
        expectAccess(2, 1'b0, 16'hFE01, 8'h00);
        expectAccess(2, 1'b1, 16'hFE02, 8'h77);
        expectAccess(2, 1'b0, 16'hFE03, 8'h00);
        expectAccess(0, 1'b0, 16'h0042, 8'h00);
        for (int k = 0; k < 4; k++) begin
            waitAck(2, 12, "burst_ack", n);
            if (k > 0) check("burst_gap", 32'(n), 32'(ACCESS_CYCLES + 1));
            if (k < 3) drive(2, 1'b1, 1'b1, (k == 1), 16'hFE00 + 16'(k + 1), 8'h77);
            else drive(2, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        end
        waitAck(0, 12, "burst_then_req0", n);
        check("burst_req0_gap", 32'(n), 32'(ACCESS_CYCLES + 2));
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);

        // lock limit: forced re-arbitration after MAX_LOCK, requester 2 wins again
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b0, 16'h0077, 8'h00);
        drive(2, 1'b1, 1'b1, 1'b0, 16'h8000, 8'h00);
        for (int k = 0; k <= MAX_LOCK; k++) expectAccess(2, 1'b0, 16'h8000, 8'h00);
        expectAccess(1, 1'b0, 16'h0077, 8'h00);
        waitAck(2, 12, "limit_first", n);
        runLen = 1;
        for (int k = 0; k < MAX_LOCK + 4; k++) begin
            waitAck(2, 12, "limit_run", n);
            if (n != ACCESS_CYCLES + 1) break;
            runLen++;
        end
        check("limit_run_len", 32'(runLen), 32'(MAX_LOCK));
        check("limit_rewin_gap", 32'(n), 32'(ACCESS_CYCLES + 2));
        drive(2, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        waitAck(1, 12, "limit_req1", n);
        check("limit_req1_gap", 32'(n), 32'(ACCESS_CYCLES + 2));
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
`endif

        // reset in the second bus cycle of a write
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b1, 16'h9000, 8'hA5);
        @(negedge clk);
        @(negedge clk);
        check("mid_rw_before", 32'(bus.RW), 32'd1);
        reset = 1'b1;
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        modelRdata = '0;
        @(negedge clk);
        check("mid_rw", 32'(bus.RW), 32'd0);
        check("mid_gnt", 32'(bus.gnt), 32'd0);
        check("mid_ack", 32'(bus.ack), 32'd0);
        check("mid_rdata", 32'(bus.rdata), 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mid_no_ack", 32'(bus.ack), 32'd0);
        end
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
        expectAccess(0, 1'b0, 16'h0010, 8'h00);
        waitAck(0, 12, "post_reset_ack", n);
        check("post_reset_lat", 32'(n), 32'(ACCESS_CYCLES + 1));
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);

`ifdef BUS_ARB_ROUND_ROBIN_EN
        // rotating order from reset: 0, 1, 2, 0
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelRdata = '0;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
        drive(1, 1'b1, 1'b0, 1'b0, 16'h0200, 8'h00);
        drive(2, 1'b1, 1'b0, 1'b0, 16'h0300, 8'h00);
        expectAccess(0, 1'b0, 16'h0100, 8'h00);
        expectAccess(1, 1'b0, 16'h0200, 8'h00);
        expectAccess(2, 1'b0, 16'h0300, 8'h00);
        expectAccess(0, 1'b0, 16'h0100, 8'h00);
        waitAck(0, 12, "rr_first0", n);
        waitAck(1, 12, "rr_1", n);
        check("rr_gap1", 32'(n), 32'(ACCESS_CYCLES + 2));
        waitAck(2, 12, "rr_2", n);
        check("rr_gap2", 32'(n), 32'(ACCESS_CYCLES + 2));
        waitAck(0, 12, "rr_second0", n);
        check("rr_gap0", 32'(n), 32'(ACCESS_CYCLES + 2));
        for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
`endif

        @(negedge clk);
        check("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit memory bus (memAddress/memDataW/memDataR/RW) between NUM_REQ requesters, e.g. CPU core, OAM DMA and PPU fetch.
- Sits between the requesters and the bus/memory decode.
- Runs one access at a time. Each access takes a fixed ACCESS_CYCLES.
- Fixed-priority arbitration, with optional bus locking for bursts.

Parameters:
- NUM_REQ, 3, number of requesters. Higher index has higher priority.
- ACCESS_CYCLES, 2, cycles RW/address are held per access before read data is sampled (>=1).
- MAX_LOCK, 160, max consecutive locked re-grants before forced re-arbitration (OAM DMA length).

Ports:
- clk  in  1  system clock (4 MHz)
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester access request, level; held until ack
- lock  in  NUM_REQ  per-requester: keep bus after current access if req still high
- addr  in  16*NUM_REQ  per-requester address, slice i = [16i+15:16i]
- wdata  in  8*NUM_REQ  per-requester write data
- we  in  NUM_REQ  per-requester direction (1 = write, 0 = read)
- gnt  out  NUM_REQ  one-hot owner of bus during access
- ack  out  NUM_REQ  one-cycle pulse: access complete, rdata valid for reads
- rdata  out  8  read data of last completed read
- memAddress  out  16  bus address
- memDataW  out  8  bus write data
- RW  out  1  bus direction (0 = read, 1 = write)
- memDataR  in  8  bus read data

Behaviour:
- Reset (sync, active-high): state=ARB; gnt=0, ack=0, rdata=0, memAddress=0, memDataW=0, RW=0; counters=0. Reset mid-access aborts it with no ack; RW is 0 in the cycle after reset.
- States: ARB, ACCESS, DONE. All outputs registered.
- ARB:
  - If any req, pick the highest set index i.
  - Register memAddress=addr[i], memDataW=wdata[i], RW=we[i], gnt=onehot(i); cnt=1; go ACCESS.
  - Else hold RW=0, gnt=0.
- ACCESS:
  - Bus outputs held stable.
  - If cnt==ACCESS_CYCLES: sample rdata<=memDataR (reads only; rdata unchanged on writes), ack[i]<=1, RW<=0, go DONE.
  - Else cnt++.
- DONE (ack visible this cycle):
  - If lock[i] && req[i] && lockcnt<MAX_LOCK-1: re-grant i directly (load new addr/wdata/we, cnt=1, lockcnt++), go ACCESS.
  - Else gnt=0, lockcnt=0, go ARB.
- Latency:
  - Uncontended read: req seen in cycle 0; bus driven cycles 1..ACCESS_CYCLES; ack high in cycle ACCESS_CYCLES+1.
  - Back-to-back unlocked accesses: 1 idle ARB cycle between them.
- Handshake rules:
  - Requester holds req/addr/wdata/we/lock stable until ack.
  - Requester drops req, or changes addr, in the ack cycle or later.
  - Dropping req mid-access does not cancel; the access completes and ack still pulses.
- Simultaneous requests: strictly the highest index wins. The loser keeps req high and is served at the next ARB.
- Lock limit: after MAX_LOCK consecutive accesses, forced return to ARB. lockcnt resets to 0.
- Equal-priority ties: impossible (index-unique).
- Invariants: gnt is one-hot or zero; at most one ack bit per cycle; ack[i] implies gnt[i] in the same cycle.

Optional Feature:
- Macro BUS_ARB_ROUND_ROBIN_EN.
- Defined: ARB uses round-robin. Search starts at (last_owner+1) mod NUM_REQ and wraps. last_owner is updated on every grant and reset to NUM_REQ-1. Lock behaviour is unchanged.
- Undefined: fixed priority as above; no last_owner register.

Decomposition:
- Shared package gb_bus_pkg:
  - state encodings ARB_IDLE=2'd0, ARB_ACCESS=2'd1, ARB_DONE=2'd2;
  - RW_READ=1'b0, RW_WRITE=1'b1;
  - bus widths ADDR_W=16, DATA_W=8.
- One sub-module, arb_pick: combinational requester select (priority or round-robin) producing index + valid. Reused by the future interrupt controller.

Test Plan:
- Single read: reset, then req[0]=1, addr0=16'hC000, we0=0, memDataR=8'h5A. Expect memAddress=C000 and RW=0 in cycles 1-2, ack[0] in cycle 3, rdata=5A.
- Single write: req[1], addr1=FF80, wdata1=8'h3C, we1=1. Expect RW=1 and memDataW=3C in cycles 1-2; RW=0 plus ack[1] in cycle 3; rdata unchanged.
- Contention: req[0] and req[2] set in the same cycle. Expect gnt=3'b100 first and ack[2], one ARB cycle, then gnt=3'b001 and ack[0].
- Lock burst: req[2]+lock[2] for 4 accesses at FE00..FE03 with req[0] pending. Expect 4 acks to requester 2 with no ARB gap, then requester 0 served. With MAX_LOCK=2: forced ARB after 2, requester 2 re-wins.
- Reset mid-access: assert reset in cycle 2 of a write. Expect RW=0, gnt=0, no ack; next request proceeds normally.
- Round-robin (macro defined): all three req held. Expect grant order 0,1,2,0 after reset (last_owner=2).
